pipe_skid: RTL and testbench

PIPE_SKID -- requirements
Module: pipe_skid

---
 rtl/pipe_pkg.sv | 13 +
 rtl/pipe_skid_ctrl.sv | 71 +++++++
 rtl/pipe_skid.sv | 62 ++++++
 tb/tb_pipe_skid.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipe_skid slice: state encodings and the
// width of the optional stall statistics counter.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam int STALL_W = 16;

endpackage

// File: rtl/pipe_skid_ctrl.sv
// Control half of the two-entry skid buffer: occupancy state machine and
// the write-enable / mux-select decode for the data registers.
module pipe_skid_ctrl
  import pipe_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic flush,
  input  logic in_valid,
  input  logic out_ready,
  output logic main_we,
  output logic skid_we,
  output logic sel_skid,
  output logic in_ready,
  output logic out_valid
);

  state_t state, state_nxt;
  logic   in_fire, out_fire;

  // Handshake outputs come only from the registered state, so neither
  // in_valid nor out_ready has a combinational path to them.
  assign out_valid = (state != EMPTY);
  assign in_ready  = (state != FULL);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= EMPTY;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    main_we   = 1'b0;
    skid_we   = 1'b0;
    sel_skid  = 1'b0;
    if (flush) begin
      // Flush only moves the state; both data registers keep their contents.
      state_nxt = EMPTY;
    end else begin
      unique case (state)
        EMPTY: begin
          if (in_fire) begin
            main_we   = 1'b1;
            state_nxt = ONE;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_we = 1'b1;
          end else if (in_fire) begin
            skid_we   = 1'b1;
            state_nxt = FULL;
          end else if (out_fire) begin
            state_nxt = EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            main_we   = 1'b1;
            sel_skid  = 1'b1;
            state_nxt = ONE;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/pipe_skid.sv
// Two-entry skid buffer (main + skid register) with valid/ready on both sides.
// Optional saturating stall counter enabled by defining PIPE_SKID_STATS_EN.
module pipe_skid
  import pipe_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out
`ifdef PIPE_SKID_STATS_EN
  ,
  output logic [STALL_W-1:0] stall_count
`endif
);

  logic [N-1:0] main_q, skid_q;
  logic         main_we, skid_we, sel_skid;

  pipe_skid_ctrl u_ctrl (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .out_ready (out_ready),
    .main_we   (main_we),
    .skid_we   (skid_we),
    .sel_skid  (sel_skid),
    .in_ready  (in_ready),
    .out_valid (out_valid)
  );

  // Main refills from the skid entry when draining FULL, otherwise from the input.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       main_q <= '0;
    else if (main_we) main_q <= sel_skid ? skid_q : in;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       skid_q <= '0;
    else if (skid_we) skid_q <= in;
  end

  assign out = main_q;

`ifdef PIPE_SKID_STATS_EN
  // Counts cycles where a word waits on downstream; survives flush by design.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      stall_count <= '0;
    else if (out_valid && !out_ready && (stall_count != '1))
      stall_count <= stall_count + STALL_W'(1);
  end
`endif

endmodule

// File: tb/tb_pipe_skid.sv
// Scoreboard bench for pipe_skid (N=8): directed stimulus pushes expected words,
// an independent monitor pops and compares on every output handshake.
module tb_pipe_skid;

  logic       clk;
  logic       reset;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] din;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] dout;
`ifdef PIPE_SKID_STATS_EN
  logic [15:0] stall_count;
`endif

  int         errors = 0;
  int         checks = 0;
  logic [7:0] sb_q[$];
  logic [7:0] exp_word;

  pipe_skid #(.N(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in        (din),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (dout)
`ifdef PIPE_SKID_STATS_EN
    ,
    .stall_count (stall_count)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle's inputs just after the edge and record what the DUT must emit.
  task automatic applyStimulus(input logic v, input logic [7:0] d,
                               input logic ordy, input logic fl);
    @(posedge clk);
    #1;
    in_valid  = v;
    din       = d;
    out_ready = ordy;
    flush     = fl;
    if (fl) sb_q.delete();
    else if (v && in_ready) sb_q.push_back(d);
  endtask

  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      checkOutput("sb_has_entry", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        exp_word = sb_q.pop_front();
        checkOutput("sb_data", 32'(dout), 32'(exp_word));
      end
    end
  end

  initial begin
    reset     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    din       = 8'h00;
    out_ready = 1'b0;

    // Reset values, then first word with one-cycle latency
    #12;
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_out", 32'(dout), 32'h00);
    reset = 1'b1;
    applyStimulus(1'b1, 8'hAA, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("first_out", 32'(dout), 32'hAA);
    checkOutput("first_valid", 32'(out_valid), 32'd1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);

    // Backpressure into FULL
    applyStimulus(1'b1, 8'h11, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h22, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
    checkOutput("bp_out", 32'(dout), 32'h11);
    checkOutput("bp_valid", 32'(out_valid), 32'd1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("bp_stable", 32'(dout), 32'h11);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("bp_out_skid", 32'(dout), 32'h22);
    checkOutput("bp_in_ready_back", 32'(in_ready), 32'd1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);

    // Streaming at full rate
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b1, 8'(i), 1'b1, 1'b0);
      checkOutput("stream_in_ready", 32'(in_ready), 32'd1);
      if (i > 1) checkOutput("stream_out", 32'(dout), 32'(i - 1));
    end
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("stream_last", 32'(dout), 32'h04);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("stream_empty", 32'(out_valid), 32'd0);

    // Flush from FULL, then flush from ONE with an acceptable input present
    applyStimulus(1'b1, 8'h33, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h44, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h55, 1'b0, 1'b1);
    checkOutput("fl_full_in_ready", 32'(in_ready), 32'd0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("fl_out_valid", 32'(out_valid), 32'd0);
    checkOutput("fl_in_ready", 32'(in_ready), 32'd1);
    checkOutput("fl_main_kept", 32'(dout), 32'h33);
    applyStimulus(1'b1, 8'h66, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h55, 1'b0, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("fl1_out_valid", 32'(out_valid), 32'd0);
    checkOutput("fl1_no_load", 32'(dout), 32'h66);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);

    // Asynchronous reset in the middle of a FULL hold
    applyStimulus(1'b1, 8'h77, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h88, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("mid_full", 32'(in_ready), 32'd0);
    #2 reset = 1'b0;
    #1;
    checkOutput("mid_rst_valid", 32'(out_valid), 32'd0);
    checkOutput("mid_rst_ready", 32'(in_ready), 32'd1);
    checkOutput("mid_rst_out", 32'(dout), 32'h00);
    sb_q.delete();
    #3 reset = 1'b1;
    applyStimulus(1'b1, 8'h99, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("post_rst_out", 32'(dout), 32'h99);
    checkOutput("post_rst_valid", 32'(out_valid), 32'd1);

    repeat (3) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("sb_drain", 32'(sb_q.size()), 32'd0);

`ifdef PIPE_SKID_STATS_EN
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    checkOutput("stat_rst", 32'(stall_count), 32'd0);
    sb_q.delete();
    out_ready = 1'b0;
    #1 reset = 1'b1;
    applyStimulus(1'b1, 8'hC3, 1'b0, 1'b0);
    repeat (6) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("stat_five", 32'(stall_count), 32'd5);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("stat_flush_keeps", 32'(stall_count), 32'd7);
    checkOutput("stat_flush_empty", 32'(out_valid), 32'd0);
    applyStimulus(1'b1, 8'hD4, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    repeat (70000) @(posedge clk);
    #1;
    checkOutput("stat_saturate", 32'(stall_count), 32'hFFFF);
    repeat (2) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("stat_drain", 32'(sb_q.size()), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
